// File: rtl/lp_ser_word_scheduler.sv
// Word-slot scheduler feeding a serializer: training burst after reset, then round-robin requester words.
// Optional macro LP_SER_SYNC_INSERT_EN forces a 16'hF0F0 sync slot every 64th RUN slot.
module lp_ser_word_scheduler #(
    parameter int unsigned REQ_NUM     = 4,
    parameter int unsigned WORD_CYCLES = 8,
    parameter int unsigned TRAIN_WORDS = 16,
    parameter logic [15:0] IDLE_WORD   = 16'h0000,
    parameter logic [15:0] TRAIN_WORD  = 16'hAAAA
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [REQ_NUM-1:0]         REQ_VALID,
    input  logic [REQ_NUM*16-1:0]      REQ_DATA,
    output logic [REQ_NUM-1:0]         REQ_READY,
    output logic [15:0]                PAR_OUT,
    output logic                       WORD_STROBE,
    output logic [$clog2(REQ_NUM)-1:0] GRANT_ID,
    output logic                       GRANT_VALID,
    output logic                       TRAINING
);

    localparam int unsigned ID_W   = $clog2(REQ_NUM);
    localparam int unsigned CNT_W  = (WORD_CYCLES > 1) ? $clog2(WORD_CYCLES) : 1;
    localparam int unsigned TC_W   = (TRAIN_WORDS > 0) ? $clog2(TRAIN_WORDS + 1) : 1;
    localparam logic [15:0] SYNC_WORD = 16'hF0F0;

    typedef enum logic {
        ST_TRAIN = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TC_W-1:0]   train_cnt_q, train_cnt_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [15:0]       par_q, par_d;
    logic              strobe_q, strobe_d;
    logic [ID_W-1:0]   gid_q, gid_d;
    logic              gval_q, gval_d;
    logic              training_q, training_d;
`ifdef LP_SER_SYNC_INSERT_EN
    logic [5:0]        sync_cnt_q, sync_cnt_d;
`endif

    logic              boundary_c;
    logic              run_sel_c;
    logic              sync_slot_c;
    logic              found_c;
    logic              grant_c;
    logic [ID_W-1:0]   gnt_idx_c;
    logic [15:0]       gnt_data_c;
    logic [REQ_NUM-1:0] ready_c;

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_TRAIN;
            cnt_q       <= '0;
            train_cnt_q <= '0;
            ptr_q       <= '0;
            par_q       <= TRAIN_WORD;
            strobe_q    <= 1'b0;
            gid_q       <= '0;
            gval_q      <= 1'b0;
            training_q  <= 1'b1;
`ifdef LP_SER_SYNC_INSERT_EN
            sync_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            train_cnt_q <= train_cnt_d;
            ptr_q       <= ptr_d;
            par_q       <= par_d;
            strobe_q    <= strobe_d;
            gid_q       <= gid_d;
            gval_q      <= gval_d;
            training_q  <= training_d;
`ifdef LP_SER_SYNC_INSERT_EN
            sync_cnt_q  <= sync_cnt_d;
`endif
        end
    end

    // Slot timing, round-robin search, next-state and next-word selection
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        train_cnt_d = train_cnt_q;
        ptr_d       = ptr_q;
        par_d       = par_q;
        strobe_d    = 1'b0;
        gid_d       = gid_q;
        gval_d      = gval_q;
        training_d  = training_q;
`ifdef LP_SER_SYNC_INSERT_EN
        sync_cnt_d  = sync_cnt_q;
        sync_slot_c = (sync_cnt_q == 6'd0);
`else
        sync_slot_c = 1'b0;
`endif
        found_c     = 1'b0;
        gnt_idx_c   = '0;
        gnt_data_c  = IDLE_WORD;
        ready_c     = '0;

        boundary_c = (cnt_q == CNT_W'(WORD_CYCLES - 1));
        cnt_d      = boundary_c ? '0 : cnt_q + 1'b1;

        // The boundary that ends the last training word already selects the first RUN slot
        run_sel_c = (state_q == ST_RUN) || (train_cnt_q == TC_W'(TRAIN_WORDS));

        // Two passes give round-robin order: indices at/after the pointer first, then wrap
        for (int i = 0; i < int'(REQ_NUM); i++) begin
            if (!found_c && REQ_VALID[i] && (ID_W'(i) >= ptr_q)) begin
                found_c   = 1'b1;
                gnt_idx_c = ID_W'(i);
            end
        end
        for (int i = 0; i < int'(REQ_NUM); i++) begin
            if (!found_c && REQ_VALID[i]) begin
                found_c   = 1'b1;
                gnt_idx_c = ID_W'(i);
            end
        end

        for (int i = 0; i < int'(REQ_NUM); i++) begin
            if (gnt_idx_c == ID_W'(i)) begin
                gnt_data_c = REQ_DATA[i*16 +: 16];
            end
        end

        grant_c = boundary_c && run_sel_c && !sync_slot_c && found_c && !RESET;

        for (int i = 0; i < int'(REQ_NUM); i++) begin
            ready_c[i] = grant_c && (gnt_idx_c == ID_W'(i));
        end

        if (boundary_c) begin
            strobe_d = 1'b1;
            if (run_sel_c) begin
                state_d    = ST_RUN;
                training_d = 1'b0;
`ifdef LP_SER_SYNC_INSERT_EN
                sync_cnt_d = sync_cnt_q + 6'd1;
`endif
                if (sync_slot_c) begin
                    par_d  = SYNC_WORD;
                    gval_d = 1'b0;
                end else if (found_c) begin
                    par_d  = gnt_data_c;
                    gid_d  = gnt_idx_c;
                    gval_d = 1'b1;
                    ptr_d  = (gnt_idx_c == ID_W'(REQ_NUM - 1)) ? '0 : gnt_idx_c + 1'b1;
                end else begin
                    par_d  = IDLE_WORD;
                    gval_d = 1'b0;
                end
            end else begin
                par_d       = TRAIN_WORD;
                gval_d      = 1'b0;
                training_d  = 1'b1;
                train_cnt_d = train_cnt_q + 1'b1;
            end
        end
    end

    // Ready is combinational so a requester can drop valid right up to the boundary cycle
    assign REQ_READY   = ready_c;
    assign PAR_OUT     = par_q;
    assign WORD_STROBE = strobe_q;
    assign GRANT_ID    = gid_q;
    assign GRANT_VALID = gval_q;
    assign TRAINING    = training_q;

endmodule

// File: doc/lp_ser_word_scheduler.md
LP_SER_WORD_SCHEDULER -- requirements
Module: lp_ser_word_scheduler

Interface
REQ-001 The block SHALL have parameter REQ_NUM, default 4, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter WORD_CYCLES, default 8, meaning the CLK cycles per 16-bit word slot.
REQ-003 The block SHALL have parameter TRAIN_WORDS, default 16, meaning the words of training pattern sent after reset.
REQ-004 The block SHALL have parameter IDLE_WORD, default 16'h0000, meaning the word sent when no request is granted.
REQ-005 The block SHALL have parameter TRAIN_WORD, default 16'hAAAA, meaning the training pattern.
REQ-006 The block SHALL have port CLK, input, 1 bit, the single clock (one clock; reset is synchronous and active-high).
REQ-007 The block SHALL have port RESET, input, 1 bit, the synchronous active-high reset.
REQ-008 The block SHALL have port REQ_VALID, input, REQ_NUM bits, meaning requester i offers a word.
REQ-009 The block SHALL have port REQ_DATA, input, REQ_NUM*16 bits, meaning requester i's word in bits [16i+15:16i].
REQ-010 The block SHALL have port REQ_READY, output, REQ_NUM bits, meaning requester i's word is accepted this cycle.
REQ-011 The block SHALL have port PAR_OUT, output, 16 bits, meaning the parallel word driving the serializer PAR_IN.
REQ-012 The block SHALL have port WORD_STROBE, output, 1 bit, meaning PAR_OUT changed this cycle.
REQ-013 The block SHALL have port GRANT_ID, output, $clog2(REQ_NUM) bits, meaning the source of the current PAR_OUT.
REQ-014 The block SHALL have port GRANT_VALID, output, 1 bit, meaning the current PAR_OUT carries requester data.
REQ-015 The block SHALL have port TRAINING, output, 1 bit, meaning the block is in the TRAIN state.

Function
REQ-016 The slot counter SHALL count 0..WORD_CYCLES-1 and wrap to 0; the cycle with count WORD_CYCLES-1 is the boundary.
REQ-017 The next word SHALL be selected at the boundary and registered into PAR_OUT on the following clock edge, with WORD_STROBE high for exactly that one cycle.
REQ-018 PAR_OUT, GRANT_ID, GRANT_VALID and TRAINING SHALL hold stable for all WORD_CYCLES cycles between strobes.
REQ-019 The FSM SHALL have two states: TRAIN (after reset) and RUN.
REQ-020 In TRAIN, every slot SHALL carry TRAIN_WORD, REQ_READY SHALL be all zero, and GRANT_VALID SHALL be 0.
REQ-021 TRAIN->RUN SHALL occur at the boundary ending the TRAIN_WORDS-th training word; RUN is left only by RESET.
REQ-022 In RUN at a boundary, the grant SHALL go to the first requester with REQ_VALID high, searching round-robin from (last granted + 1) mod REQ_NUM; the pointer starts at 0.
REQ-023 REQ_READY[i] SHALL be high only in a boundary cycle, only for the granted i, and only when REQ_VALID[i] is high (one-hot or zero).
REQ-024 The transfer SHALL occur when REQ_VALID[i] and REQ_READY[i] are both high; REQ_DATA[i] is sampled in that cycle.
REQ-025 The round-robin pointer SHALL update only on a transfer.
REQ-026 If no REQ_VALID is high at a boundary, the slot SHALL carry IDLE_WORD with GRANT_VALID=0, and GRANT_ID SHALL keep its previous value.
REQ-027 REQ_VALID deasserted outside the boundary cycle SHALL have no effect; only the boundary-cycle value matters.
REQ-028 A single requester with continuous REQ_VALID SHALL be granted every slot; when all requesters are valid, each SHALL be granted once per REQ_NUM slots.

Reset
REQ-029 When RESET is high at a clock edge: slot counter=0, state=TRAIN, training count=0, round-robin pointer=0, PAR_OUT=TRAIN_WORD, WORD_STROBE=0, GRANT_ID=0, GRANT_VALID=0, TRAINING=1, REQ_READY=0.
REQ-030 RESET asserted mid-slot or mid-RUN SHALL abort the slot immediately with no transfer, and the first post-reset boundary SHALL fall WORD_CYCLES-1 cycles after RESET deasserts.

Configuration
REQ-031 Macro LP_SER_SYNC_INSERT_EN, when defined, SHALL force every 64th RUN slot (the first RUN slot, then every 64th slot after it) to carry 16'hF0F0 with REQ_READY all zero, GRANT_VALID=0, and the round-robin pointer unchanged.
REQ-032 Without LP_SER_SYNC_INSERT_EN, no sync slots SHALL exist, and all RUN slots follow REQ-022..REQ-026.

Verification
REQ-033 Scenario: reset, then no requests -> 16 strobes with PAR_OUT=16'hAAAA and TRAINING=1, then PAR_OUT=16'h0000 with TRAINING=0; strobes exactly 8 cycles apart.
REQ-034 Scenario: RUN, requester 2 holds valid with data 16'h1234 -> REQ_READY[2] high only in boundary cycles; next strobe PAR_OUT=16'h1234, GRANT_ID=2, GRANT_VALID=1.
REQ-035 Scenario: all 4 requesters continuously valid -> GRANT_ID sequence 0,1,2,3,0 on consecutive strobes.
REQ-036 Scenario: RESET pulsed at slot count 3 during requester 1 traffic -> no REQ_READY pulse; TRAINING=1; next strobe 8 cycles after RESET deasserts carries 16'hAAAA.
REQ-037 Scenario: with LP_SER_SYNC_INSERT_EN, all requesters valid -> first RUN slot is 16'hF0F0, then GRANT_IDs 0,1,2,...; slot 64 after it is again 16'hF0F0, with the round-robin order resuming uninterrupted.
